lsu: RTL and testbench

Load-store unit for the single-cycle RV32I core, directly downstream of the ALU: it takes the ALU result as the effective address and performs LB/LH/LW/LBU/LHU/SB/SH/SW against an on-chip data memory and a small memory-mapped I/O space. Loads return data combinationally in the same cycle, in time for writeback. Stores and I/O output registers update on the rising clock edge.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_dmem.sv | 33 +++
 rtl/lsu.sv | 216 +++++++++++++++++++++
 tb/tb_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load-store unit.
//   - lsu_funct3_e : funct3 encodings of the RV32I load/store instructions
//   - IO_*_PAGE    : address bits [31:12] of each memory-mapped I/O page
//   - lsu_region_e : result of the address decode
//   - merge_bytes  : byte-enable merge of a new word into an old word
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  localparam logic [19:0] IO_LEDR_PAGE   = 20'h10000;
  localparam logic [19:0] IO_LEDG_PAGE   = 20'h10001;
  localparam logic [19:0] IO_HEX_LO_PAGE = 20'h10002;
  localparam logic [19:0] IO_HEX_HI_PAGE = 20'h10003;
  localparam logic [19:0] IO_SW_PAGE     = 20'h10010;
  localparam logic [19:0] IO_BTN_PAGE    = 20'h10011;

  typedef enum logic [2:0] {
    RGN_DMEM   = 3'd0,
    RGN_LEDR   = 3'd1,
    RGN_LEDG   = 3'd2,
    RGN_HEX_LO = 3'd3,
    RGN_HEX_HI = 3'd4,
    RGN_SW     = 3'd5,
    RGN_BTN    = 3'd6,
    RGN_NONE   = 3'd7
  } lsu_region_e;

  // Bytes with be[i]=1 come from new_word, the rest keep old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem: word-organized data memory, byte-enable synchronous write,
// asynchronous read. Contents are not reset.
// Ports:
//   i_clk    clock (writes on rising edge)
//   i_wr_en  write strobe
//   i_be     per-byte write enables
//   i_idx    word index
//   i_wdata  write data, already steered into the enabled lanes
//   o_rdata  word at i_idx (combinational; a same-cycle write is not visible)
module lsu_dmem #(
  parameter int DMEM_WORDS = 2048
) (
  input  logic                          i_clk,
  input  logic                          i_wr_en,
  input  logic [3:0]                    i_be,
  input  logic [$clog2(DMEM_WORDS)-1:0] i_idx,
  input  logic [31:0]                   i_wdata,
  output logic [31:0]                   o_rdata
);
  import lsu_pkg::*;

  logic [31:0] mem_q [DMEM_WORDS];

  // Byte-enabled word write.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem_q[i_idx] <= merge_bytes(mem_q[i_idx], i_wdata, i_be);
    end
  end

  assign o_rdata = mem_q[i_idx];

endmodule

// File: rtl/lsu.sv
// lsu: RV32I load-store unit. Decodes the effective address into DMEM or
// memory-mapped I/O, steers byte/half/word lanes, extends load data and
// holds the LED/HEX output registers.
// Optional feature macro: LSU_IO_SYNC_EN -- when defined, switches and
// buttons pass through 2-flop synchronizers (reset to 0) before being read.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_lsu_addr            effective address
//   i_st_data             store data
//   i_lsu_wren            1 = store
//   i_lsu_funct3          access size/extension
//   i_io_sw, i_io_btn     board switches / buttons
//   o_ld_data             combinational load result
//   o_misaligned          current access is misaligned
//   o_io_ledr, o_io_ledg  LED registers
//   o_io_hex_lo/hi        seven-segment registers (one code per byte lane)
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_lsu_funct3,
  input  logic [31:0] i_io_sw,
  input  logic [3:0]  i_io_btn,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex_lo,
  output logic [31:0] o_io_hex_hi
);

  localparam int IDX_W  = $clog2(DMEM_WORDS);
  localparam int BYTE_W = IDX_W + 2;

  lsu_region_e region_s;
  logic        fn_ok_s;
  logic        misaligned_s;
  logic        store_en_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] dmem_rdata_s;
  logic [31:0] rd_word_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ld_data_s;
  logic [31:0] sw_val_s;
  logic [3:0]  btn_val_s;
  logic [31:0] ledr_d, ledr_q, ledg_d, ledg_q;
  logic [31:0] hex_lo_d, hex_lo_q, hex_hi_d, hex_hi_q;

  // Address decode: DMEM only when every bit above the DMEM span is zero (no aliasing).
  always_comb begin
    region_s = RGN_NONE;
    if (i_lsu_addr[31:BYTE_W] == '0) begin
      region_s = RGN_DMEM;
    end else begin
      case (i_lsu_addr[31:12])
        IO_LEDR_PAGE:   region_s = RGN_LEDR;
        IO_LEDG_PAGE:   region_s = RGN_LEDG;
        IO_HEX_LO_PAGE: region_s = RGN_HEX_LO;
        IO_HEX_HI_PAGE: region_s = RGN_HEX_HI;
        IO_SW_PAGE:     region_s = RGN_SW;
        IO_BTN_PAGE:    region_s = RGN_BTN;
        default:        region_s = RGN_NONE;
      endcase
    end
  end

  // Access size: byte enables, replicated store lanes and alignment check.
  always_comb begin
    fn_ok_s      = 1'b1;
    misaligned_s = 1'b0;
    be_s         = 4'b0000;
    wdata_s      = i_st_data;
    case (i_lsu_funct3)
      LSU_B, LSU_BU: begin
        be_s    = 4'b0001 << i_lsu_addr[1:0];
        wdata_s = {4{i_st_data[7:0]}};
      end
      LSU_H, LSU_HU: begin
        misaligned_s = i_lsu_addr[0];
        be_s         = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s      = {2{i_st_data[15:0]}};
      end
      LSU_W: begin
        misaligned_s = |i_lsu_addr[1:0];
        be_s         = 4'b1111;
      end
      default: fn_ok_s = 1'b0;
    endcase
  end

  // A store held across reset is dropped, including its DMEM write.
  assign store_en_s = i_lsu_wren & fn_ok_s & ~misaligned_s & i_rst_n;

  lsu_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
    .i_clk   (i_clk),
    .i_wr_en (store_en_s & (region_s == RGN_DMEM)),
    .i_be    (be_s),
    .i_idx   (i_lsu_addr[BYTE_W-1:2]),
    .i_wdata (wdata_s),
    .o_rdata (dmem_rdata_s)
  );

`ifdef LSU_IO_SYNC_EN
  logic [31:0] sw_meta_q, sw_sync_q;
  logic [3:0]  btn_meta_q, btn_sync_q;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_meta_q  <= 32'h0000_0000;
      sw_sync_q  <= 32'h0000_0000;
      btn_meta_q <= 4'h0;
      btn_sync_q <= 4'h0;
    end else begin
      sw_meta_q  <= i_io_sw;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= i_io_btn;
      btn_sync_q <= btn_meta_q;
    end
  end

  assign sw_val_s  = sw_sync_q;
  assign btn_val_s = btn_sync_q;
`else
  assign sw_val_s  = i_io_sw;
  assign btn_val_s = i_io_btn;
`endif

  // Read-word mux by region; unmapped reads as zero.
  always_comb begin
    case (region_s)
      RGN_DMEM:   rd_word_s = dmem_rdata_s;
      RGN_LEDR:   rd_word_s = ledr_q;
      RGN_LEDG:   rd_word_s = ledg_q;
      RGN_HEX_LO: rd_word_s = hex_lo_q;
      RGN_HEX_HI: rd_word_s = hex_hi_q;
      RGN_SW:     rd_word_s = sw_val_s;
      RGN_BTN:    rd_word_s = {28'h000_0000, btn_val_s};
      default:    rd_word_s = 32'h0000_0000;
    endcase
  end

  // Lane select and sign/zero extension; misaligned or invalid access loads zero.
  always_comb begin
    case (i_lsu_addr[1:0])
      2'd0:    byte_s = rd_word_s[7:0];
      2'd1:    byte_s = rd_word_s[15:8];
      2'd2:    byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    half_s    = i_lsu_addr[1] ? rd_word_s[31:16] : rd_word_s[15:0];
    ld_data_s = 32'h0000_0000;
    if (misaligned_s) begin
      ld_data_s = 32'h0000_0000;
    end else begin
      case (i_lsu_funct3)
        LSU_B:   ld_data_s = {{24{byte_s[7]}}, byte_s};
        LSU_BU:  ld_data_s = {24'h00_0000, byte_s};
        LSU_H:   ld_data_s = {{16{half_s[15]}}, half_s};
        LSU_HU:  ld_data_s = {16'h0000, half_s};
        LSU_W:   ld_data_s = rd_word_s;
        default: ld_data_s = 32'h0000_0000;
      endcase
    end
  end

  // Next state of the I/O output registers: merge enabled lanes on a store hit.
  always_comb begin
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    hex_lo_d = hex_lo_q;
    hex_hi_d = hex_hi_q;
    if (store_en_s) begin
      case (region_s)
        RGN_LEDR:   ledr_d   = merge_bytes(ledr_q, wdata_s, be_s);
        RGN_LEDG:   ledg_d   = merge_bytes(ledg_q, wdata_s, be_s);
        RGN_HEX_LO: hex_lo_d = merge_bytes(hex_lo_q, wdata_s, be_s);
        RGN_HEX_HI: hex_hi_d = merge_bytes(hex_hi_q, wdata_s, be_s);
        default:    ledr_d   = ledr_q;
      endcase
    end else begin
      ledr_d = ledr_q;
    end
  end

  // I/O output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q   <= 32'h0000_0000;
      ledg_q   <= 32'h0000_0000;
      hex_lo_q <= 32'h0000_0000;
      hex_hi_q <= 32'h0000_0000;
    end else begin
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      hex_lo_q <= hex_lo_d;
      hex_hi_q <= hex_hi_d;
    end
  end

  assign o_ld_data    = ld_data_s;
  assign o_misaligned = misaligned_s;
  assign o_io_ledr    = ledr_q;
  assign o_io_ledg    = ledg_q;
  assign o_io_hex_lo  = hex_lo_q;
  assign o_io_hex_hi  = hex_hi_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: self-checking bench for lsu. A byte-level memory model and
// per-register I/O models predict load data, misalignment and LED/HEX
// state; directed steps are followed by randomized accesses.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, st;
  logic        wren;
  logic [2:0]  f3;
  logic [31:0] sw_pin;
  logic [3:0]  btn_pin;
  logic [31:0] ld_data, ledr, ledg, hex_lo, hex_hi;
  logic        mis;

  lsu dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_addr   (addr),
    .i_st_data    (st),
    .i_lsu_wren   (wren),
    .i_lsu_funct3 (f3),
    .i_io_sw      (sw_pin),
    .i_io_btn     (btn_pin),
    .o_ld_data    (ld_data),
    .o_misaligned (mis),
    .o_io_ledr    (ledr),
    .o_io_ledg    (ledg),
    .o_io_hex_lo  (hex_lo),
    .o_io_hex_hi  (hex_hi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  dm [0:8191];
  logic [31:0] ledr_m, ledg_m, hexlo_m, hexhi_m;

`ifdef LSU_IO_SYNC_EN
  // Reference delay line: pin value seen two rising edges later.
  logic [31:0] sw_h1, sw_h2;
  logic [3:0]  btn_h1, btn_h2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_h1 <= 32'h0; sw_h2 <= 32'h0; btn_h1 <= 4'h0; btn_h2 <= 4'h0;
    end else begin
      sw_h1 <= sw_pin; sw_h2 <= sw_h1; btn_h1 <= btn_pin; btn_h2 <= btn_h1;
    end
  end
  function automatic logic [31:0] sw_vis();
    return sw_h2;
  endfunction
  function automatic logic [3:0] btn_vis();
    return btn_h2;
  endfunction
`else
  function automatic logic [31:0] sw_vis();
    return sw_pin;
  endfunction
  function automatic logic [3:0] btn_vis();
    return btn_pin;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from funct3; 0 for an invalid encoding.
  function automatic int sz(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_mis(input logic [31:0] a, input logic [2:0] f);
    int s = sz(f);
    return (s != 0) && ((int'(a[1:0]) % s) != 0);
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int b;
    if (a < 32'd8192) begin
      b = int'(a & 32'h0000_1FFC);
      return {dm[b+3], dm[b+2], dm[b+1], dm[b]};
    end
    case (a[31:12])
      20'h10000: return ledr_m;
      20'h10001: return ledg_m;
      20'h10002: return hexlo_m;
      20'h10003: return hexhi_m;
      20'h10010: return sw_vis();
      20'h10011: return {28'h0, btn_vis()};
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f);
    int s = sz(f);
    logic [31:0] w;
    if (s == 0 || is_mis(a, f)) return 32'h0;
    w = m_word(a) >> (8 * int'(a[1:0]));
    if (s == 4) return w;
    if (s == 2) return f[2] ? (w & 32'h0000_FFFF) : 32'($signed(w[15:0]));
    return f[2] ? (w & 32'h0000_00FF) : 32'($signed(w[7:0]));
  endfunction

  task automatic apply_store(input logic [31:0] a, input logic [2:0] f,
                             input logic we, input logic [31:0] d);
    int s = sz(f);
    int off;
    logic [7:0] by;
    if (!we || s == 0 || is_mis(a, f)) return;
    for (int i = 0; i < s; i++) begin
      off = int'(a[1:0]) + i;
      by  = d[8*i +: 8];
      if (a < 32'd8192) dm[int'(a & 32'h0000_1FFC) + off] = by;
      else begin
        case (a[31:12])
          20'h10000: ledr_m[8*off +: 8] = by;
          20'h10001: ledg_m[8*off +: 8] = by;
          20'h10002: hexlo_m[8*off +: 8] = by;
          20'h10003: hexhi_m[8*off +: 8] = by;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk_io(input string tag);
    chk({tag, " ledr"}, ledr, ledr_m);
    chk({tag, " ledg"}, ledg, ledg_m);
    chk({tag, " hex_lo"}, hex_lo, hexlo_m);
    chk({tag, " hex_hi"}, hex_hi, hexhi_m);
  endtask

  // One access: drive after the falling edge, check before the next rising edge.
  task automatic op(input logic [31:0] a, input logic [2:0] f, input logic we,
                    input logic [31:0] d, input bit chk_ld);
    string tag;
    @(negedge clk);
    addr = a; f3 = f; wren = we; st = d;
    #1;
    tag = $sformatf("a=%h f3=%0d we=%0d", a, f, we);
    if (chk_ld) chk({tag, " ld_data"}, ld_data, exp_load(a, f));
    chk({tag, " misaligned"}, {31'b0, mis}, {31'b0, is_mis(a, f)});
    chk_io(tag);
    apply_store(a, f, we, d);
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    rst_n = 1'b0; wren = 1'b0; addr = 32'h0; f3 = 3'd2; st = 32'h0;
    sw_pin = 32'h0; btn_pin = 4'h0;
    ledr_m = 32'h0; ledg_m = 32'h0; hexlo_m = 32'h0; hexhi_m = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_io("reset");
    rst_n = 1'b1;

    // Fill the DMEM window used by the bench.
    for (int i = 0; i < 64; i++) op(32'(i * 4), 3'd2, 1'b1, $urandom, 1'b0);

    op(32'h10, 3'd2, 1'b1, 32'h1122_3344, 1'b0);
    op(32'h10, 3'd2, 1'b0, 32'h0, 1'b1); chk("lw_0x10", ld_data, 32'h1122_3344);
    op(32'h13, 3'd0, 1'b0, 32'h0, 1'b1); chk("lb_0x13", ld_data, 32'h0000_0011);
    op(32'h10, 3'd4, 1'b0, 32'h0, 1'b1); chk("lbu_0x10", ld_data, 32'h0000_0044);
    op(32'h12, 3'd1, 1'b0, 32'h0, 1'b1); chk("lh_0x12", ld_data, 32'h0000_1122);

    op(32'h20, 3'd2, 1'b1, 32'hFFFF_FFFF, 1'b1);
    op(32'h21, 3'd0, 1'b1, 32'h0000_0000, 1'b1);
    op(32'h20, 3'd2, 1'b0, 32'h0, 1'b1); chk("lw_after_sb", ld_data, 32'hFFFF_00FF);
    op(32'h22, 3'd1, 1'b1, 32'h0000_8001, 1'b1);
    op(32'h22, 3'd1, 1'b0, 32'h0, 1'b1); chk("lh_0x22", ld_data, 32'hFFFF_8001);
    op(32'h22, 3'd5, 1'b0, 32'h0, 1'b1); chk("lhu_0x22", ld_data, 32'h0000_8001);

    op(32'h1000_0000, 3'd2, 1'b1, 32'h0000_00AA, 1'b1);
    op(32'h1000_0000, 3'd2, 1'b0, 32'h0, 1'b1);
    chk("ledr_after_sw", ledr, 32'h0000_00AA);
    chk("lw_ledr", ld_data, 32'h0000_00AA);
    op(32'h1000_1000, 3'd2, 1'b1, 32'h0000_0055, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("ledr_async_rst", ledr, 32'h0);
    ledr_m = 32'h0; ledg_m = 32'h0; hexlo_m = 32'h0; hexhi_m = 32'h0;
    chk_io("in_reset");
    // Store held across reset must be dropped.
    addr = 32'h30; f3 = 3'd2; wren = 1'b1; st = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; wren = 1'b0;
    op(32'h30, 3'd2, 1'b0, 32'h0, 1'b1);
    op(32'h34, 3'd2, 1'b1, 32'hCAFE_F00D, 1'b1);
    op(32'h34, 3'd2, 1'b0, 32'h0, 1'b1); chk("first_store_after_rst", ld_data, 32'hCAFE_F00D);

    op(32'h6, 3'd2, 1'b1, 32'hDEAD_BEEF, 1'b1);
    chk("sw_mis_flag", {31'b0, mis}, 32'h1); chk("sw_mis_ld", ld_data, 32'h0);
    op(32'h4, 3'd2, 1'b0, 32'h0, 1'b1);
    op(32'h5, 3'd1, 1'b0, 32'h0, 1'b1);
    chk("lh5_mis", {31'b0, mis}, 32'h1); chk("lh5_ld", ld_data, 32'h0);
    op(32'h6, 3'd1, 1'b0, 32'h0, 1'b1); chk("lh6_mis", {31'b0, mis}, 32'h0);
    op(32'h8, 3'd3, 1'b1, 32'h1111_1111, 1'b1); chk("inv_f3_ld", ld_data, 32'h0);
    op(32'h8, 3'd2, 1'b0, 32'h0, 1'b1);

    sw_pin = 32'h5A;
    op(32'h1001_0000, 3'd2, 1'b0, 32'h0, 1'b1);
`ifdef LSU_IO_SYNC_EN
    chk("sw_sync_1", ld_data, 32'h0);
`else
    chk("sw_direct_1", ld_data, 32'h5A);
`endif
    op(32'h1001_0000, 3'd2, 1'b0, 32'h0, 1'b1); chk("sw_read_2", ld_data, 32'h5A);

    op(32'h2000_0000, 3'd2, 1'b1, 32'h0000_1234, 1'b1);
    op(32'h2000_0000, 3'd2, 1'b0, 32'h0, 1'b1); chk("unmapped_ld", ld_data, 32'h0);
    op(32'h0000_2000, 3'd2, 1'b0, 32'h0, 1'b1); chk("no_alias_ld", ld_data, 32'h0);
    op(32'h0000_0000, 3'd2, 1'b0, 32'h0, 1'b1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw_pin  = $urandom;
        btn_pin = 4'($urandom);
      end
      sel = int'($urandom_range(0, 9));
      case (sel)
        5:       a = 32'h1000_0000 + (32'($urandom_range(0, 3)) << 12) + 32'($urandom_range(0, 4095));
        6:       a = 32'h1001_0000 + (32'($urandom_range(0, 1)) << 12) + 32'($urandom_range(0, 4095));
        7:       a = 32'h2000_0000 | $urandom;
        8:       a = 32'h0000_2000 + 32'($urandom_range(0, 32'h0FFF_0000));
        9:       a = 32'h1000_4000 + 32'($urandom_range(0, 32'h000B_FFFF));
        default: a = 32'($urandom_range(0, 255));
      endcase
      op(a, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
